// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared constants for the instruction fetch queue
package inst_fetch_queue_pkg;

  localparam int                  IFQ_XLEN     = 32;
  localparam int                  IFQ_DEPTH    = 4;
  localparam logic [IFQ_XLEN-1:0] INST_NOP     = 32'h0000_0013;
  localparam logic [IFQ_XLEN-1:0] IFQ_RESET_PC = 32'h0000_0000;

  // Occupancy counters need one bit more than the pointers to tell full from empty.
  function automatic int ifq_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - redirect, memory and ID handshake bundle of the fetch queue
interface inst_fetch_queue_if
  import inst_fetch_queue_pkg::*;
#(
  parameter int XLEN = IFQ_XLEN
);

  logic            flush_i;
  logic [XLEN-1:0] flush_addr_i;
  logic            req_valid_o;
  logic [XLEN-1:0] req_addr_o;
  logic            req_ready_i;
  logic            rsp_valid_i;
  logic [XLEN-1:0] rsp_inst_i;
  logic            inst_valid_o;
  logic [XLEN-1:0] inst_o;
  logic [XLEN-1:0] inst_addr_o;
  logic            id_ready_i;
  logic            empty_o;
  logic            full_o;

  // Fetch queue side.
  modport slave (
    input  flush_i, flush_addr_i, req_ready_i, rsp_valid_i, rsp_inst_i, id_ready_i,
    output req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o, empty_o, full_o
  );

  // Surrounding pipeline / memory side.
  modport master (
    output flush_i, flush_addr_i, req_ready_i, rsp_valid_i, rsp_inst_i, id_ready_i,
    input  req_valid_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o, empty_o, full_o
  );

endinterface

// File: rtl/inst_fetch_queue_fifo.sv
// rtl/inst_fetch_queue_fifo.sv - synchronous FIFO with clear, used for addresses and fetched entries
module ifq_fifo
  import inst_fetch_queue_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = ifq_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array, no reset needed since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - prefetching fetch stage; IFQ_BYPASS_EN adds memory-to-ID bypass
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int              XLEN     = IFQ_XLEN,
  parameter int              DEPTH    = IFQ_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = IFQ_RESET_PC,
  parameter logic [XLEN-1:0] NOP_INST = INST_NOP
) (
  input logic                clk,
  input logic                rst_n,
  inst_fetch_queue_if.slave  bus
);

  localparam int CW = ifq_cnt_w(DEPTH);
  localparam int SW = CW + 2;

  logic [XLEN-1:0]   fetch_pc;
  logic [CW-1:0]     outstanding;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     a_count;
  logic [SW-1:0]     inflight;
  logic [2*XLEN-1:0] q_rdata;
  logic [XLEN-1:0]   a_rdata;
  logic              q_full, q_empty, a_full, a_empty;
  logic              req_fire, rsp_keep, rsp_drop;
  logic              q_push, q_pop;
  logic              bypass_valid, bypass_take;

  // Everything already queued, in flight or still to be dropped counts against capacity.
  assign inflight        = SW'(q_count) + SW'(outstanding) + SW'(discard);
  assign bus.req_valid_o = rst_n && !bus.flush_i && (inflight < SW'(DEPTH));
  assign bus.req_addr_o  = fetch_pc;
  assign req_fire        = bus.req_valid_o && bus.req_ready_i;

  assign rsp_drop = bus.rsp_valid_i && (discard != '0);
  assign rsp_keep = bus.rsp_valid_i && (discard == '0);

`ifdef IFQ_BYPASS_EN
  assign bypass_valid = q_empty && rsp_keep;
`else
  assign bypass_valid = 1'b0;
`endif
  assign bypass_take = bypass_valid && bus.id_ready_i;

  assign q_push = rsp_keep && !bypass_take;
  assign q_pop  = !q_empty && bus.id_ready_i;

  ifq_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_addr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.flush_i),
    .push  (req_fire),
    .wdata (fetch_pc),
    .pop   (rsp_keep),
    .rdata (a_rdata),
    .count (a_count),
    .full  (a_full),
    .empty (a_empty)
  );

  ifq_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_inst_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.flush_i),
    .push  (q_push),
    .wdata ({a_rdata, bus.rsp_inst_i}),
    .pop   (q_pop),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  assign bus.empty_o = q_empty;
  assign bus.full_o  = q_full;

  // Head presentation: queued entry first, else the bypassed response, else a NOP.
  always_comb begin
    bus.inst_valid_o = 1'b0;
    bus.inst_o       = NOP_INST;
    bus.inst_addr_o  = '0;
    if (!q_empty) begin
      bus.inst_valid_o = 1'b1;
      bus.inst_addr_o  = q_rdata[2*XLEN-1:XLEN];
      bus.inst_o       = q_rdata[XLEN-1:0];
    end else if (bypass_valid) begin
      bus.inst_valid_o = 1'b1;
      bus.inst_addr_o  = a_rdata;
      bus.inst_o       = bus.rsp_inst_i;
    end
  end

  // Fetch PC and in-flight accounting; a redirect turns every pending response into a drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else if (bus.flush_i) begin
      fetch_pc    <= bus.flush_addr_i;
      outstanding <= '0;
      discard     <= discard + outstanding - CW'(bus.rsp_valid_i);
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_keep);
      if (rsp_drop) discard <= discard - CW'(1);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(q_push && q_full && !q_pop));
  a_rsp_has_addr: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_keep && a_empty));
  a_addr_room: assert property (@(posedge clk) disable iff (!rst_n)
    !(req_fire && a_full));
  a_addr_tracks: assert property (@(posedge clk) disable iff (!rst_n)
    (a_count == outstanding));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed scoreboard bench for inst_fetch_queue
module tb_inst_fetch_queue;

  localparam int XLEN = 32;
  localparam int DEPTH = 4;
`ifdef IFQ_BYPASS_EN
  localparam int   EXP_FIRST       = 1;
  localparam logic EXP_FIRST_EMPTY = 1'b1;
`else
  localparam int   EXP_FIRST       = 2;
  localparam logic EXP_FIRST_EMPTY = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.XLEN(XLEN)) bus ();

  inst_fetch_queue #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc, lat, reqs, fires, first_valid;
  logic        first_empty, watch, got_first, wrap_seen, found;
  logic [31:0] first_addr, exp_pc, last_req_addr;
  logic [63:0] exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_1013;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.flush_i = 1'b0;
    bus.id_ready_i = 1'b1;
    bus.req_ready_i = 1'b1;
    bus.rsp_valid_i = 1'b0;
    pend_addr.delete();
    pend_due.delete();
    exp_q.delete();
    exp_pc = 32'h0;
    last_req_addr = 32'h0;
    first_valid = -1;
    reqs = 0;
    fires = 0;
    watch = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_req_valid", 64'(bus.req_valid_o), 64'd0);
    chk("rst_inst_valid", 64'(bus.inst_valid_o), 64'd0);
    chk("rst_inst", 64'(bus.inst_o), 64'h13);
    chk("rst_inst_addr", 64'(bus.inst_addr_o), 64'd0);
    chk("rst_empty", 64'(bus.empty_o), 64'd1);
    chk("rst_full", 64'(bus.full_o), 64'd0);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic cycle();
    logic [63:0] e;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      bus.rsp_valid_i = 1'b1;
      bus.rsp_inst_i = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      bus.rsp_valid_i = 1'b0;
      bus.rsp_inst_i = 32'hDEAD_BEEF;
    end
    #1;
    if (bus.flush_i) chk("flush_req_valid", 64'(bus.req_valid_o), 64'd0);
    if (bus.req_valid_o && bus.req_ready_i) begin
      chk("req_addr", 64'(bus.req_addr_o), 64'(exp_pc));
      if (last_req_addr == 32'hFFFF_FFFC) begin
        chk("req_wrap", 64'(bus.req_addr_o), 64'd0);
        wrap_seen = 1'b1;
      end
      last_req_addr = bus.req_addr_o;
      pend_addr.push_back(bus.req_addr_o);
      pend_due.push_back(cyc + lat);
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      exp_pc = exp_pc + 32'd4;
      reqs++;
    end
    if (bus.inst_valid_o) begin
      if (first_valid < 0) begin
        first_valid = cyc;
        first_empty = bus.empty_o;
      end
      if (watch && !got_first) begin
        got_first = 1'b1;
        first_addr = bus.inst_addr_o;
      end
      chk("head_present", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q[0];
        chk("head_addr", 64'(bus.inst_addr_o), 64'(e[63:32]));
        chk("head_inst", 64'(bus.inst_o), 64'(e[31:0]));
        if (bus.id_ready_i) begin
          void'(exp_q.pop_front());
          fires++;
        end
      end
    end else begin
      chk("idle_inst", 64'(bus.inst_o), 64'h13);
      chk("idle_addr", 64'(bus.inst_addr_o), 64'd0);
    end
    if (bus.flush_i) begin
      exp_q.delete();
      exp_pc = bus.flush_addr_i;
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_flush(input logic [31:0] addr);
    bus.flush_i = 1'b1;
    bus.flush_addr_i = addr;
    cycle();
    bus.flush_i = 1'b0;
    watch = 1'b1;
    got_first = 1'b0;
  endtask

  initial begin
    bus.flush_i = 1'b0;
    bus.flush_addr_i = 32'h0;
    bus.req_ready_i = 1'b1;
    bus.rsp_valid_i = 1'b0;
    bus.rsp_inst_i = 32'h0;
    bus.id_ready_i = 1'b1;
    wrap_seen = 1'b0;
    got_first = 1'b0;
    first_addr = 32'h0;
    first_empty = 1'b0;

    // Zero-wait streaming from reset, including first-valid latency.
    lat = 1;
    do_reset();
    repeat (12) cycle();
    chk("t1_first_valid", 64'(first_valid), 64'(EXP_FIRST));
    chk("t1_first_empty", 64'(first_empty), 64'(EXP_FIRST_EMPTY));
    chk("t1_fires", 64'(fires), 64'(12 - EXP_FIRST));

    // ID stall fills the queue, then drains one per cycle.
    do_reset();
    bus.id_ready_i = 1'b0;
    repeat (10) cycle();
    chk("t2_reqs", 64'(reqs), 64'd4);
    chk("t2_full", 64'(bus.full_o), 64'd1);
    chk("t2_req_valid", 64'(bus.req_valid_o), 64'd0);
    chk("t2_head_addr", 64'(bus.inst_addr_o), 64'd0);
    chk("t2_head_inst", 64'(bus.inst_o), 64'(mem_word(32'h0)));
    bus.id_ready_i = 1'b1;
    fires = 0;
    repeat (4) cycle();
    chk("t2_drain", 64'(fires), 64'd4);

    // Redirect with responses still in flight on a slow memory.
    lat = 3;
    do_reset();
    repeat (6) cycle();
    for (int i = 0; i < 20; i++) begin
      if (pend_addr.size() >= 2) break;
      cycle();
    end
    chk("t3_inflight", 64'(pend_addr.size() >= 2), 64'd1);
    do_flush(32'h0000_0100);
    repeat (15) cycle();
    chk("t3_got", 64'(got_first), 64'd1);
    chk("t3_first_addr", 64'(first_addr), 64'h100);

    // Redirect coinciding with a response and a dequeue.
    lat = 2;
    bus.id_ready_i = 1'b0;
    repeat (3) cycle();
    bus.id_ready_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.empty_o && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
        found = 1'b1;
        break;
      end
      cycle();
    end
    chk("t4_setup", 64'(found), 64'd1);
    do_flush(32'h0000_0200);
    chk("t4_empty", 64'(bus.empty_o), 64'd1);
    repeat (12) cycle();
    chk("t4_got", 64'(got_first), 64'd1);
    chk("t4_first_addr", 64'(first_addr), 64'h200);

    // Fetch PC wraps past the top of the address space.
    lat = 1;
    wrap_seen = 1'b0;
    do_flush(32'hFFFF_FFF8);
    repeat (10) cycle();
    chk("t5_wrap_seen", 64'(wrap_seen), 64'd1);
    chk("t5_first_addr", 64'(first_addr), 64'hFFFF_FFF8);

    // Reset in the middle of traffic, then restart.
    do_reset();
    repeat (6) cycle();
    chk("t6_first_valid", 64'(first_valid), 64'(EXP_FIRST));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
